// File: rtl/plantard_arb_pkg.sv
// Shared constants for the Plantard multiplier arbiter: FSM encodings,
// default core latency and modulus width, and the result tag layout.
package plantard_arb_pkg;
  localparam int DEF_LAT = 3;
  localparam int DEF_QW  = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;
endpackage

// File: rtl/plantard_arb_s.sv
// Plantard-style multiplier core: c_ = (((a*b >> k1) mod 2^QW) + 1) * q >> m,
// delivered through a LAT-deep register pipeline.
module plantard_s
  import plantard_arb_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int QW  = DEF_QW
) (
  input  logic          clk,
  input  logic [31:0]   a,
  input  logic [QW-1:0] b,
  input  logic [7:0]    k1,
  input  logic [7:0]    m,
  input  logic [QW-1:0] q,
  output logic [QW-1:0] c_
);

  function automatic logic [QW-1:0] plantard_f(input logic [31:0] fa, input logic [QW-1:0] fb,
                                               input logic [7:0] fk1, input logic [7:0] fm,
                                               input logic [QW-1:0] fq);
    logic [QW+31:0]  prod;
    logic [QW-1:0]   red;
    logic [2*QW-1:0] wide;
    prod = (QW+32)'(fa) * (QW+32)'(fb);
    red  = QW'(prod >> fk1);
    wide = ((2*QW)'(red) + (2*QW)'(1)) * (2*QW)'(fq);
    return QW'(wide >> fm);
  endfunction

  logic [QW-1:0] c_pipe [LAT];

  // The product is formed ahead of the register chain so retiming can spread it across stages.
  always_ff @(posedge clk) begin
    c_pipe[0] <= plantard_f(a, b, k1, m, q);
    for (int i = 1; i < LAT; i++) c_pipe[i] <= c_pipe[i-1];
  end

  assign c_ = c_pipe[LAT-1];

endmodule

// File: rtl/plantard_arb.sv
// Two-requester round-robin front end for a shared fixed-latency Plantard core,
// with a drain-then-load handshake for swapping the modulus constants.
module plantard_arb
  import plantard_arb_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int QW  = DEF_QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  input  logic          s1_valid,
  output logic          s0_ready,
  output logic          s1_ready,
  input  logic [31:0]   s0_a,
  input  logic [31:0]   s1_a,
  input  logic [QW-1:0] s0_b,
  input  logic [QW-1:0] s1_b,
  input  logic          cfg_req,
  input  logic [7:0]    cfg_k1,
  input  logic [7:0]    cfg_m,
  input  logic [QW-1:0] cfg_q,
  output logic          cfg_ack,
  output logic          r_valid,
  output logic          r_id,
  output logic [QW-1:0] r_data,
  output logic          busy
);

  localparam int IW = $clog2(LAT + 2);

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] inflight;
  logic          last_gnt;
  logic          accept_en, gnt0, gnt1, xfer, drained;
  logic [7:0]    k1, m;
  logic [QW-1:0] q;
  logic [31:0]   a_p0;
  logic [QW-1:0] b_p0;
  tag_t          tag_p0;
  tag_t          tag_pipe [LAT];
  logic [QW-1:0] core_c;

  // A pending cfg_req blocks issue immediately, so nothing new enters while draining.
  assign accept_en = !rst && !cfg_req && (state == S_IDLE || state == S_RUN);
  assign gnt0      = accept_en && s0_valid && (!s1_valid || last_gnt);
  assign gnt1      = accept_en && s1_valid && (!s0_valid || !last_gnt);
  assign xfer      = gnt0 || gnt1;
  assign s0_ready  = gnt0;
  assign s1_ready  = gnt1;

  assign r_valid = !rst && tag_pipe[LAT-1].vld;
  assign r_id    = !rst && tag_pipe[LAT-1].id;
  assign r_data  = core_c;
  assign cfg_ack = !rst && (state == S_LOAD);
  assign busy    = !rst && (state != S_IDLE || inflight != '0);

  // Leaving DRAIN on the last result's cycle lets cfg_ack follow it by exactly one cycle.
  assign drained = (inflight == '0) || (inflight == IW'(1) && r_valid);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_req) state_nxt = S_DRAIN;
               else if (xfer) state_nxt = S_RUN;
      S_RUN:   if (cfg_req) state_nxt = S_DRAIN;
               else if (inflight == '0 && !xfer) state_nxt = S_IDLE;
      S_DRAIN: if (drained) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      inflight <= '0;
      last_gnt <= 1'b1;
      k1       <= '0;
      m        <= '0;
      q        <= '0;
      tag_p0   <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && !r_valid) inflight <= inflight + IW'(1);
      else if (!xfer && r_valid) inflight <= inflight - IW'(1);
      if (xfer) last_gnt <= gnt1;
      if (state == S_LOAD) begin
        k1 <= cfg_k1;
        m  <= cfg_m;
        q  <= cfg_q;
      end
      // Stage p0: tag captured with the operands; p1..pLAT track the core pipeline.
      tag_p0 <= '{vld: xfer, id: gnt1};
      tag_pipe[0] <= tag_p0;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      a_p0 <= gnt1 ? s1_a : s0_a;
      b_p0 <= gnt1 ? s1_b : s0_b;
    end
  end

  plantard_s #(.LAT(LAT), .QW(QW)) u_core (
    .clk (clk),
    .a   (a_p0),
    .b   (b_p0),
    .k1  (k1),
    .m   (m),
    .q   (q),
    .c_  (core_c)
  );

endmodule

// File: tb/tb_plantard_arb.sv
// Directed bench for plantard_arb: reset values, single-op latency, round-robin,
// drain/load of constants, mid-flight reset and cfg/valid collision.
module tb_plantard_arb;
  localparam int LAT = 3;
  localparam int QW  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic [31:0]   s0_a, s1_a;
  logic [QW-1:0] s0_b, s1_b;
  logic          cfg_req, cfg_ack;
  logic [7:0]    cfg_k1, cfg_m;
  logic [QW-1:0] cfg_q;
  logic          r_valid, r_id, busy;
  logic [QW-1:0] r_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  plantard_arb #(.LAT(LAT), .QW(QW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_ready(s0_ready), .s1_ready(s1_ready),
    .s0_a(s0_a), .s1_a(s1_a), .s0_b(s0_b), .s1_b(s1_b),
    .cfg_req(cfg_req), .cfg_k1(cfg_k1), .cfg_m(cfg_m), .cfg_q(cfg_q), .cfg_ack(cfg_ack),
    .r_valid(r_valid), .r_id(r_id), .r_data(r_data), .busy(busy)
  );

  function automatic logic [63:0] gold(input logic [31:0] a, input logic [63:0] b,
                                       input logic [7:0] k1, input logic [7:0] m,
                                       input logic [63:0] q);
    logic [95:0]  p;
    logic [95:0]  sh;
    logic [127:0] w;
    p  = {64'd0, a} * {32'd0, b};
    sh = p >> k1;
    w  = ({64'd0, sh[63:0]} + 128'd1) * {64'd0, q};
    w  = w >> m;
    return w[63:0];
  endfunction

  task automatic do_cfg(input logic [7:0] k1, input logic [7:0] m, input logic [63:0] q);
    bit seen;
    seen = 0;
    @(negedge clk);
    cfg_req = 1'b1; cfg_k1 = k1; cfg_m = m; cfg_q = q;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (cfg_ack === 1'b1) seen = 1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL cfg_ack_timeout: got no ack, want ack within 20 cycles");
    end
    cfg_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; cfg_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1; cfg_req = 1'b0;
    s0_a = '0; s1_a = '0; s0_b = '0; s1_b = '0; cfg_k1 = '0; cfg_m = '0; cfg_q = '0;
    repeat (2) @(negedge clk);
    #1;
    vecs++; if (s0_ready !== 1'b0) begin errs++; $display("FAIL rst_s0_ready: got %b want 0", s0_ready); end
    vecs++; if (s1_ready !== 1'b0) begin errs++; $display("FAIL rst_s1_ready: got %b want 0", s1_ready); end
    vecs++; if (cfg_ack !== 1'b0) begin errs++; $display("FAIL rst_cfg_ack: got %b want 0", cfg_ack); end
    vecs++; if (r_valid !== 1'b0) begin errs++; $display("FAIL rst_r_valid: got %b want 0", r_valid); end
    vecs++; if (r_id !== 1'b0) begin errs++; $display("FAIL rst_r_id: got %b want 0", r_id); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic single_op(input string tag, input logic [31:0] a, input logic [63:0] b,
                           input logic [63:0] exp);
    for (int i = 0; i <= LAT + 2; i++) begin
      @(negedge clk);
      s0_valid = (i == 0); s0_a = a; s0_b = b;
      #1;
      if (i == 0) begin
        vecs++; if (s0_ready !== 1'b1) begin errs++; $display("FAIL %s_ready: got %b want 1", tag, s0_ready); end
      end
      vecs++;
      if (r_valid !== (i == LAT + 1)) begin
        errs++; $display("FAIL %s_r_valid cyc%0d: got %b want %b", tag, i, r_valid, (i == LAT + 1));
      end
      if (i == LAT + 1) begin
        vecs++; if (r_id !== 1'b0) begin errs++; $display("FAIL %s_r_id: got %b want 0", tag, r_id); end
        vecs++; if (r_data !== exp) begin errs++; $display("FAIL %s_r_data: got %h want %h", tag, r_data, exp); end
      end
    end
  endtask

  task automatic test_single();
    do_cfg(8'h00, 8'h00, 64'd1);
    single_op("hand", 32'd3, 64'd5, 64'd16);
    do_cfg(8'h0C, 8'h13, 64'h7FF80001);
    single_op("golden", 32'h4D843C8F, 64'h9EDBD117D3C59A2A,
              gold(32'h4D843C8F, 64'h9EDBD117D3C59A2A, 8'h0C, 8'h13, 64'h7FF80001));
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    apply_reset();
    for (int i = 0; i < LAT + 9; i++) begin
      @(negedge clk);
      s0_valid = (i < 6); s1_valid = (i < 6);
      s0_a = 32'(i + 1); s0_b = 64'(i + 7); s1_a = 32'(i + 11); s1_b = 64'(i + 13);
      #1;
      if (i < 6) begin
        vecs++; if (s0_ready !== (i % 2 == 0)) begin errs++; $display("FAIL rr_s0_ready cyc%0d: got %b want %b", i, s0_ready, (i % 2 == 0)); end
        vecs++; if (s1_ready !== (i % 2 == 1)) begin errs++; $display("FAIL rr_s1_ready cyc%0d: got %b want %b", i, s1_ready, (i % 2 == 1)); end
      end
      exp_v = (i >= LAT + 1) && (i <= LAT + 6);
      vecs++; if (r_valid !== exp_v) begin errs++; $display("FAIL rr_r_valid cyc%0d: got %b want %b", i, r_valid, exp_v); end
      if (exp_v) begin
        vecs++; if (r_id !== ((i - LAT - 1) % 2 == 1)) begin errs++; $display("FAIL rr_r_id cyc%0d: got %b want %b", i, r_id, ((i - LAT - 1) % 2 == 1)); end
        vecs++; if (r_data !== 64'd0) begin errs++; $display("FAIL rr_r_data cyc%0d: got %h want 0", i, r_data); end
      end
    end
  endtask

  task automatic test_cfg_drain();
    logic        exp_v;
    logic [63:0] exp_d;
    logic        exp_id;
    do_cfg(8'h00, 8'h00, 64'd1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      s0_valid = (i < 3); s0_a = 32'(2 * i + 2); s0_b = 64'(2 * i + 3);
      cfg_req = (i >= 3 && i <= 7); cfg_k1 = 8'h00; cfg_m = 8'h00; cfg_q = 64'd2;
      s1_valid = (i >= 3 && i <= 8); s1_a = 32'd3; s1_b = 64'd5;
      #1;
      if (i < 3) begin
        vecs++; if (s0_ready !== 1'b1) begin errs++; $display("FAIL drain_s0_ready cyc%0d: got %b want 1", i, s0_ready); end
      end
      if (i >= 3 && i <= 7) begin
        vecs++; if (s1_ready !== 1'b0) begin errs++; $display("FAIL drain_s1_blocked cyc%0d: got %b want 0", i, s1_ready); end
      end
      if (i == 8) begin
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("FAIL drain_s1_after cyc%0d: got %b want 1", i, s1_ready); end
      end
      vecs++; if (cfg_ack !== (i == 7)) begin errs++; $display("FAIL drain_cfg_ack cyc%0d: got %b want %b", i, cfg_ack, (i == 7)); end
      exp_v = 1'b1; exp_id = 1'b0;
      case (i)
        4:  exp_d = 64'd7;
        5:  exp_d = 64'd21;
        6:  exp_d = 64'd43;
        12: begin exp_d = 64'd32; exp_id = 1'b1; end
        default: begin exp_d = '0; exp_v = 1'b0; end
      endcase
      vecs++; if (r_valid !== exp_v) begin errs++; $display("FAIL drain_r_valid cyc%0d: got %b want %b", i, r_valid, exp_v); end
      if (exp_v) begin
        vecs++; if (r_data !== exp_d) begin errs++; $display("FAIL drain_r_data cyc%0d: got %0d want %0d", i, r_data, exp_d); end
        vecs++; if (r_id !== exp_id) begin errs++; $display("FAIL drain_r_id cyc%0d: got %b want %b", i, r_id, exp_id); end
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      rst = (i == 2); s0_valid = (i == 0); s1_valid = (i == 1);
      s0_a = 32'd9; s0_b = 64'd9; s1_a = 32'd4; s1_b = 64'd4;
      #1;
      if (i == 0) begin
        vecs++; if (s0_ready !== 1'b1) begin errs++; $display("FAIL rstmid_s0_ready: got %b want 1", s0_ready); end
      end
      if (i == 1) begin
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("FAIL rstmid_s1_ready: got %b want 1", s1_ready); end
      end
      if (i == 3) begin
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      end
      if (i >= 2) begin
        vecs++; if (r_valid !== 1'b0) begin errs++; $display("FAIL rstmid_r_valid cyc%0d: got %b want 0", i, r_valid); end
      end
    end
  endtask

  task automatic test_cfg_collision();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cfg_req = (i <= 2); cfg_k1 = 8'h00; cfg_m = 8'h00; cfg_q = 64'd1;
      s0_valid = 1'b0; s1_valid = (i <= 3); s1_a = 32'd3; s1_b = 64'd5;
      #1;
      if (i <= 2) begin
        vecs++; if (s1_ready !== 1'b0) begin errs++; $display("FAIL coll_s1_blocked cyc%0d: got %b want 0", i, s1_ready); end
      end
      if (i == 3) begin
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("FAIL coll_s1_accept: got %b want 1", s1_ready); end
      end
      if (i <= 3) begin
        vecs++; if (cfg_ack !== (i == 2)) begin errs++; $display("FAIL coll_cfg_ack cyc%0d: got %b want %b", i, cfg_ack, (i == 2)); end
      end
      vecs++; if (r_valid !== (i == 7)) begin errs++; $display("FAIL coll_r_valid cyc%0d: got %b want %b", i, r_valid, (i == 7)); end
      if (i == 7) begin
        vecs++; if (r_data !== 64'd16) begin errs++; $display("FAIL coll_r_data: got %0d want 16", r_data); end
        vecs++; if (r_id !== 1'b1) begin errs++; $display("FAIL coll_r_id: got %b want 1", r_id); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg_drain();
    test_rst_mid();
    test_cfg_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
